// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, state typedefs and round helper functions.
// The SHA-224 IV is present only when SHA224_EN is defined.
package sha256_pkg;

    typedef logic [0:7][31:0]  state_t;
    typedef logic [0:15][31:0] win_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam state_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

`ifdef SHA224_EN
    localparam state_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h plus K and W in,
// updated a..h out.
module sha256_round
    import sha256_pkg::*;
(
    input  state_t      state_in,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output state_t      state_out
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = state_in[7] + big_sigma1(state_in[4]) + ch(state_in[4], state_in[5], state_in[6]) + k + w;
        t2 = big_sigma0(state_in[0]) + maj(state_in[0], state_in[1], state_in[2]);
        state_out = {t1 + t2, state_in[0], state_in[1], state_in[2],
                     state_in[3] + t1, state_in[4], state_in[5], state_in[6]};
    end

endmodule

// File: rtl/sha256_iter_core.sv
// Iterative multi-block SHA-256 engine, ROUNDS_PER_CYCLE rounds per clock.
// Define SHA224_EN to add the mode224 port and SHA-224 digests.
module sha256_iter_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [0:511] block_data,
    input  logic         block_first,
    input  logic         block_last,
`ifdef SHA224_EN
    input  logic         mode224,
`endif
    output logic [0:255] digest,
    output logic         digest_valid,
    output logic         busy
);

    localparam int         R        = ROUNDS_PER_CYCLE;
    localparam logic [5:0] R_STEP   = 6'(R);
    localparam logic [5:0] LAST_CNT = 6'(64 - R);

    if (R != 1 && R != 2 && R != 4 && R != 8 && R != 16) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    logic [1:0] state;
    logic [5:0] round_cnt;
    logic       last_flag;
    state_t     h_reg;
    state_t     work;
    state_t     rounds_out;
    state_t     h_new;
    state_t     digest_next;
    state_t     iv_sel;
    win_t       w_win;
    win_t       w_win_next;
`ifdef SHA224_EN
    logic       mode_q;
`endif

    // Window always holds W[t..t+15]; extend by R words and slide forward.
    function automatic win_t schedule_step(input win_t win);
        logic [0:31][31:0] ext;
        win_t              nxt;
        ext = '0;
        for (int i = 0; i < 16; i++) ext[i] = win[i];
        for (int i = 16; i < 16 + R; i++)
            ext[i] = small_sigma1(ext[i-2]) + ext[i-7] + small_sigma0(ext[i-15]) + ext[i-16];
        for (int i = 0; i < 16; i++) nxt[i] = ext[i+R];
        return nxt;
    endfunction

    for (genvar j = 0; j < R; j++) begin : g_round
        state_t     s_in;
        state_t     s_out;
        logic [5:0] k_idx;
        if (j == 0) begin : g_head
            assign s_in = work;
        end else begin : g_link
            assign s_in = g_round[j-1].s_out;
        end
        assign k_idx = round_cnt + 6'(j);
        sha256_round u_round (
            .state_in  (s_in),
            .k         (K[k_idx]),
            .w         (w_win[j]),
            .state_out (s_out)
        );
    end

    assign rounds_out  = g_round[R-1].s_out;
    assign block_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);

    always_comb begin
        w_win_next = schedule_step(w_win);
        for (int i = 0; i < 8; i++) h_new[i] = h_reg[i] + work[i];
        digest_next = h_new;
`ifdef SHA224_EN
        if (mode_q) digest_next[7] = '0;
        iv_sel = mode224 ? IV224 : IV256;
`else
        iv_sel = IV256;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            round_cnt    <= '0;
            last_flag    <= 1'b0;
            h_reg        <= IV256;
            work         <= '0;
            w_win        <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
`ifdef SHA224_EN
            mode_q       <= 1'b0;
`endif
        end else begin
            digest_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (block_valid) begin
                        w_win     <= block_data;
                        last_flag <= block_last;
                        round_cnt <= '0;
                        state     <= ST_ROUND;
                        if (block_first) begin
                            h_reg <= iv_sel;
                            work  <= iv_sel;
`ifdef SHA224_EN
                            mode_q <= mode224;
`endif
                        end else begin
                            work <= h_reg;
                        end
                    end
                end
                ST_ROUND: begin
                    work      <= rounds_out;
                    w_win     <= w_win_next;
                    round_cnt <= round_cnt + R_STEP;
                    if (round_cnt == LAST_CNT) state <= ST_FINAL;
                end
                ST_FINAL: begin
                    h_reg <= h_new;
                    if (last_flag) begin
                        digest       <= digest_next;
                        digest_valid <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_iter_core.sv
// Directed self-checking bench for sha256_iter_core with R=1 and R=4 instances.
// Adds a SHA-224 vector when SHA224_EN is defined.
module tb_sha256_iter_core;

    localparam logic [0:511] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [0:511] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [0:511] BLK_TWO_1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [0:511] BLK_TWO_2 = {{15{32'h0}}, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         reset;
    logic         block_valid;
    logic         block_first;
    logic         block_last;
    logic         sel;
    logic [0:511] block_data;
    logic         valid_r1, valid_r4;
    logic         ready_r1, ready_r4;
    logic         dv_r1, dv_r4;
    logic         busy_r1, busy_r4;
    logic [0:255] digest_r1, digest_r4;
`ifdef SHA224_EN
    logic         mode224;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign valid_r1 = block_valid && !sel;
    assign valid_r4 = block_valid && sel;

    sha256_iter_core #(.ROUNDS_PER_CYCLE(1)) u_dut_r1 (
        .clk          (clk),
        .reset        (reset),
        .block_valid  (valid_r1),
        .block_ready  (ready_r1),
        .block_data   (block_data),
        .block_first  (block_first),
        .block_last   (block_last),
`ifdef SHA224_EN
        .mode224      (mode224),
`endif
        .digest       (digest_r1),
        .digest_valid (dv_r1),
        .busy         (busy_r1)
    );

    sha256_iter_core #(.ROUNDS_PER_CYCLE(4)) u_dut_r4 (
        .clk          (clk),
        .reset        (reset),
        .block_valid  (valid_r4),
        .block_ready  (ready_r4),
        .block_data   (block_data),
        .block_first  (block_first),
        .block_last   (block_last),
`ifdef SHA224_EN
        .mode224      (mode224),
`endif
        .digest       (digest_r4),
        .digest_valid (dv_r4),
        .busy         (busy_r4)
    );

    function automatic logic cur_ready();
        return sel ? ready_r4 : ready_r1;
    endfunction

    function automatic logic cur_dv();
        return sel ? dv_r4 : dv_r1;
    endfunction

    function automatic logic [255:0] cur_digest();
        return sel ? digest_r4 : digest_r1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Waits for ready (bounded), presents one block for a single accept edge.
    task automatic apply_stimulus(input logic use_r4, input logic [0:511] data,
                                  input logic first, input logic last);
        int guard;
        guard = 0;
        sel = use_r4;
        while (!cur_ready() && guard < 200) begin
            tick();
            guard++;
        end
        block_data  = data;
        block_first = first;
        block_last  = last;
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
    endtask

    task automatic wait_digest(input int limit, output int lat, output logic [255:0] dig);
        lat = -1;
        dig = '0;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if (cur_dv()) begin
                lat = n;
                dig = cur_digest();
                break;
            end
        end
    endtask

    initial begin
        int           lat;
        int           low_cnt;
        int           pulses;
        logic [255:0] dig;
        logic [255:0] dig_a;

        reset       = 1'b1;
        block_valid = 1'b0;
        block_first = 1'b0;
        block_last  = 1'b0;
        block_data  = '0;
        sel         = 1'b0;
`ifdef SHA224_EN
        mode224     = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] reset state");
        check_output("rst_ready_r1", 256'(ready_r1), 256'(1));
        check_output("rst_busy_r1", 256'(busy_r1), 256'(0));
        check_output("rst_dv_r1", 256'(dv_r1), 256'(0));
        check_output("rst_digest_r1", digest_r1, 256'h0);
        check_output("rst_digest_r4", digest_r4, 256'h0);

        $display("[TB] abc, R=1");
        apply_stimulus(1'b0, BLK_ABC, 1'b1, 1'b1);
        check_output("abc_ready_low", 256'(ready_r1), 256'(0));
        check_output("abc_busy_high", 256'(busy_r1), 256'(1));
        wait_digest(100, lat, dig);
        check_output("abc_latency", 256'(lat), 256'(65));
        check_output("abc_digest", dig, DIG_ABC);
        tick();
        check_output("abc_pulse_width", 256'(dv_r1), 256'(0));
        check_output("abc_digest_held", digest_r1, DIG_ABC);

        $display("[TB] empty, R=4");
        apply_stimulus(1'b1, BLK_EMPTY, 1'b1, 1'b1);
        wait_digest(40, lat, dig);
        check_output("empty_latency", 256'(lat), 256'(17));
        check_output("empty_digest", dig, DIG_EMPTY);

        $display("[TB] two-block message, R=4");
        apply_stimulus(1'b1, BLK_TWO_1, 1'b1, 1'b0);
        wait_digest(30, lat, dig);
        check_output("two_blk1_no_pulse", 256'(lat), 256'(-1));
        check_output("two_blk1_digest_untouched", digest_r4, DIG_EMPTY);
        apply_stimulus(1'b1, BLK_TWO_2, 1'b0, 1'b1);
        wait_digest(40, lat, dig);
        check_output("two_blk2_latency", 256'(lat), 256'(17));
        check_output("two_blk2_digest", dig, DIG_TWO);

        $display("[TB] back-to-back, R=4");
        sel         = 1'b1;
        block_data  = BLK_ABC;
        block_first = 1'b1;
        block_last  = 1'b1;
        block_valid = 1'b1;
        tick();
        block_data = BLK_EMPTY;
        low_cnt    = 0;
        dig_a      = '0;
        while (!ready_r4 && low_cnt < 100) begin
            low_cnt++;
            tick();
        end
        if (dv_r4) dig_a = digest_r4;
        check_output("b2b_ready_low_cycles", 256'(low_cnt), 256'(17));
        check_output("b2b_first_digest", dig_a, DIG_ABC);
        tick();
        block_valid = 1'b0;
        wait_digest(40, lat, dig);
        check_output("b2b_second_latency", 256'(lat), 256'(17));
        check_output("b2b_second_digest", dig, DIG_EMPTY);

        $display("[TB] reset mid-block, R=1");
        apply_stimulus(1'b0, BLK_ABC, 1'b1, 1'b1);
        repeat (29) tick();
        reset = 1'b1;
        tick();
        check_output("midrst_ready", 256'(ready_r1), 256'(1));
        check_output("midrst_busy", 256'(busy_r1), 256'(0));
        check_output("midrst_digest", digest_r1, 256'h0);
        check_output("midrst_dv", 256'(dv_r1), 256'(0));
        reset  = 1'b0;
        pulses = 0;
        for (int n = 0; n < 70; n++) begin
            tick();
            if (dv_r1) pulses++;
        end
        check_output("midrst_no_pulse", 256'(pulses), 256'(0));
        apply_stimulus(1'b0, BLK_ABC, 1'b1, 1'b1);
        wait_digest(100, lat, dig);
        check_output("midrst_fresh_latency", 256'(lat), 256'(65));
        check_output("midrst_fresh_digest", dig, DIG_ABC);

`ifdef SHA224_EN
        $display("[TB] SHA-224 abc, R=4");
        mode224 = 1'b1;
        apply_stimulus(1'b1, BLK_ABC, 1'b1, 1'b1);
        mode224 = 1'b0;
        wait_digest(40, lat, dig);
        check_output("sha224_latency", 256'(lat), 256'(17));
        check_output("sha224_digest", dig,
                     256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_iter_core.md
Name: sha256_iter_core

Overview:
Iterative, multi-block SHA-256 compression engine; successor to the fully-unrolled single-block hasher.
- Accepts pre-padded 512-bit blocks over a valid/ready handshake.
- Chains the intermediate hash across blocks.
- Folds the 64 rounds into 64/ROUNDS_PER_CYCLE clock cycles, trading area for latency.
- Sits between a message-padding/UART front end and the digest formatter.

Parameters:
ROUNDS_PER_CYCLE, 1, rounds unrolled per clock; legal values 1, 2, 4, 8, 16; other values are an elaboration error.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
block_valid  in  1  block_data/block_first/block_last valid
block_ready  out  1  core can accept a block
block_data  in  512  [0:511]; word i = bits [i*32 +: 32], bit 0 = MSB of word 0 (big-endian)
block_first  in  1  block starts a new message; load IV before compressing
block_last  in  1  block ends the message; publish digest
digest  out  256  [0:255]; H0 at bits [0:31]
digest_valid  out  1  one-cycle pulse; digest updated this cycle
busy  out  1  compression in progress

Behaviour:
- Reset values: block_ready=1, digest_valid=0, busy=0, digest=0, H=IV, FSM=IDLE, round counter=0.
- States:
  - IDLE: block_ready=1.
    - Accept on block_valid&&block_ready.
    - Latch the 16 W words into a 16-entry rolling schedule window.
    - Load a..h from the IV if block_first, else from the current H.
    - Latch last_flag. Go to ROUND.
  - ROUND: busy=1, block_ready=0.
    - Each cycle applies ROUNDS_PER_CYCLE rounds using K[t..t+R-1] and W[t..t+R-1].
    - W[t>=16] = Si1(W[t-2]) + W[t-7] + Si0(W[t-15]) + W[t-16], all mod 2^32; the window shifts R words per cycle.
    - Round counter advances by R.
    - After the cycle covering round 63, go to FINAL.
  - FINAL: H[i] <= H_base[i] + var[i], mod 2^32.
    - If last_flag: digest <= new H and digest_valid pulses in the same cycle.
    - Go to IDLE.
- Latency, accept edge to FINAL edge: 64/R + 1 cycles; 65 for R=1, 17 for R=4.
- Throughput: one block per 64/R + 2 cycles.
- block_ready is low during ROUND and FINAL.
- block_first && block_last on the same block is a single-block message.
- block_first=0 immediately after reset chains from the IV, since H resets to the IV.
- Inputs are ignored while block_ready=0; no buffering.
- digest holds its value until the next last-block FINAL. Intermediate blocks never touch digest or digest_valid.
- Reset mid-operation returns all state to reset values next edge; no digest_valid for the aborted message; the in-flight block is lost.
- Arithmetic: all additions are 32-bit modular and rotations are 32-bit. Σ0/Σ1/σ0/σ1/Ch/Maj are per FIPS 180-4.

Optional Feature:
SHA224_EN
- Defined: adds input port mode224 (1 bit), sampled at accept when block_first=1 and held for the message.
  - mode224=1 loads the SHA-224 IV.
  - Digest bits [0:223] carry H0..H6; bits [224:255] are forced to 0.
  - mode224 is ignored when block_first=0.
- Undefined: no port; SHA-256 only.

Decomposition:
- Shared package sha256_pkg holds:
  - K[0:63] constant array and the SHA-256 IV.
  - SHA-224 IV, under SHA224_EN.
  - Round helper functions: rotr, ch, maj, Σ0, Σ1, σ0, σ1.
  - A state-vector typedef of 8×32-bit words.
- One natural sub-module, sha256_round: a single combinational round (a..h, K, W in; a..h out). Instantiate ROUNDS_PER_CYCLE copies in a generate chain.

Test Plan:
- Single block, message "abc" (61626380…00000018), first=last=1, R=1 → digest_valid 65 cycles after accept; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (80000000…0), R=4 → digest_valid 17 cycles after accept; digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", first then last → no digest_valid after block 1; after block 2 digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Back-to-back: block_valid held high with two single-block messages ("abc", then empty) → block_ready low for 64/R+1 cycles between accepts; both digests correct and independent, proving IV reload.
- Reset asserted at round 30 of "abc" → next cycle block_ready=1, busy=0, digest=0, no pulse; a fresh "abc" afterwards gives the correct digest.
- SHA224_EN, mode224=1, "abc" → digest[0:223] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7; digest[224:255] = 0.
